// File: rtl/pll_model_pkg.sv
// Shared types and constants for the PLL divider model.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pll_model_pkg;

   typedef enum logic {
      LOCKING = 1'b0,
      RUN     = 1'b1
   } lock_state_e;

   localparam int MAX_OUT = 8;                // hardware limit on output channels
   localparam int SEL_W   = $clog2(MAX_OUT);  // width of the channel select field
   localparam int LOCK_W  = 16;               // lock counter width

endpackage

// File: rtl/pll_divider_model_if.sv
// Configuration bundle for the PLL divider model: load strobe, channel select,
//   divide/phase values and the reject pulse. Latency: n/a (wires only).
// Backpressure: none; a load is taken or rejected in the cycle it is presented.
interface pll_divider_model_if #(
   parameter int DIV_W = 8
);
   logic             cfg_load;
   logic [2:0]       cfg_sel;
   logic [DIV_W-1:0] cfg_div;
   logic [DIV_W-1:0] cfg_phase;
   logic             cfg_err;

   modport master (output cfg_load, cfg_sel, cfg_div, cfg_phase, input cfg_err);
   modport slave  (input cfg_load, cfg_sel, cfg_div, cfg_phase, output cfg_err);
endinterface

// File: rtl/pll_div_chan.sv
// One divider channel: divide/phase registers, phase-aligned counter and
//   registered CLKOUT/CE. Latency: outputs are flops, valid the cycle after the
//   controlling state. Backpressure: none.
// Ports: clk_i/rst_n_i clock and async reset; run_i = next cycle is a RUN cycle;
//   realign_i = reload counter from phase; load_i/div_i/phase_i = new config.
module pll_div_chan #(
   parameter int               DIV_W      = 8,
   parameter logic [DIV_W-1:0] DIV_INIT   = 1,
   parameter logic [DIV_W-1:0] PHASE_INIT = 0
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             run_i,
   input  logic             realign_i,
   input  logic             load_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic [DIV_W-1:0] phase_i,
   output logic             clkout_o,
   output logic             ce_o
);
   localparam logic [DIV_W-1:0] ONE      = 1;
   localparam logic [DIV_W-1:0] CNT_INIT = PHASE_INIT % DIV_INIT;

   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] phase_q, phase_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W:0]   high;
   logic             clkout_q, clkout_d;
   logic             ce_q, ce_d;

   always_comb begin
      div_d   = load_i ? div_i : div_q;
      phase_d = load_i ? phase_i : phase_q;
      // One extra bit so (DIV+1)/2 cannot overflow at the maximum divide.
      high    = ({1'b0, div_d} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
      // While locking the counter sits at the phase offset, so the first RUN
      // cycle already shows the phase-shifted position.
      if (realign_i) begin
         cnt_d = phase_d % div_d;
      end else if (cnt_q == div_q - ONE) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + ONE;
      end
      clkout_d = run_i && ({1'b0, cnt_d} < high);
      ce_d     = run_i && (cnt_d == '0);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         div_q    <= DIV_INIT;
         phase_q  <= PHASE_INIT;
         cnt_q    <= CNT_INIT;
         clkout_q <= 1'b0;
         ce_q     <= 1'b0;
      end else begin
         div_q    <= div_d;
         phase_q  <= phase_d;
         cnt_q    <= cnt_d;
         clkout_q <= clkout_d;
         ce_q     <= ce_d;
      end
   end

   assign clkout_o = clkout_q;
   assign ce_o     = ce_q;
endmodule

// File: rtl/pll_divider_model.sv
// Behavioural PLL divider: lock FSM, lock counter, config decode and NUM_OUT
//   divider channels. Latency: LOCKED rises LOCK_CYCLES edges after reset or a
//   load; CFG_ERR one cycle after a rejected load. Backpressure: none.
// Ports: CLKIN/RST_N clock and async active-low reset; CFG_LOAD/SEL/DIV/PHASE
//   reprogram one channel; CLKOUT/CE divided clocks and period enables;
//   LOCKED all channels running; CFG_ERR rejected-load pulse.
module pll_divider_model
   import pll_model_pkg::*;
#(
   parameter int                       NUM_OUT     = 4,
   parameter int                       DIV_W       = 8,
   parameter logic [NUM_OUT*DIV_W-1:0] DIVIDE_INIT = {NUM_OUT{{{(DIV_W-1){1'b0}}, 1'b1}}},
   parameter logic [NUM_OUT*DIV_W-1:0] PHASE_INIT  = '0,
   parameter int                       LOCK_CYCLES = 16
) (
   input  logic               CLKIN,
   input  logic               RST_N,
   input  logic               CFG_LOAD,
   input  logic [SEL_W-1:0]   CFG_SEL,
   input  logic [DIV_W-1:0]   CFG_DIV,
   input  logic [DIV_W-1:0]   CFG_PHASE,
   output logic [NUM_OUT-1:0] CLKOUT,
   output logic [NUM_OUT-1:0] CE,
   output logic               LOCKED,
   output logic               CFG_ERR
);
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
   localparam logic [SEL_W:0]    NUM_SEL   = (SEL_W + 1)'(NUM_OUT);

   lock_state_e       state_q, state_d;
   logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
   logic              locked_q;
   logic              err_q;
   logic              cfg_ok, cfg_bad;
   logic              run, realign;

   assign cfg_ok  = CFG_LOAD && (CFG_DIV != '0) && ({1'b0, CFG_SEL} < NUM_SEL);
   assign cfg_bad = CFG_LOAD && !cfg_ok;

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      // An accepted load always wins: every channel realigns from a fresh count.
      if (cfg_ok) begin
         state_d    = LOCKING;
         lock_cnt_d = '0;
      end else if (state_q == LOCKING) begin
         if (lock_cnt_q == LOCK_LAST) begin
            state_d = RUN;
         end else begin
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
         end
      end
   end

   // Channels advance only across two consecutive RUN cycles; any other
   // transition parks them at their phase offset.
   assign run     = (state_d == RUN);
   assign realign = !((state_q == RUN) && (state_d == RUN));

   always_ff @(posedge CLKIN or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= LOCKING;
         lock_cnt_q <= '0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         locked_q   <= (state_d == RUN);
         err_q      <= cfg_bad;
      end
   end

   assign LOCKED  = locked_q;
   assign CFG_ERR = err_q;

   for (genvar i = 0; i < NUM_OUT; i++) begin : g_chan
      localparam logic [SEL_W-1:0] IDX = SEL_W'(i);
      pll_div_chan #(
         .DIV_W      (DIV_W),
         .DIV_INIT   (DIVIDE_INIT[i*DIV_W +: DIV_W]),
         .PHASE_INIT (PHASE_INIT[i*DIV_W +: DIV_W])
      ) u_chan (
         .clk_i     (CLKIN),
         .rst_n_i   (RST_N),
         .run_i     (run),
         .realign_i (realign),
         .load_i    (cfg_ok && (CFG_SEL == IDX)),
         .div_i     (CFG_DIV),
         .phase_i   (CFG_PHASE),
         .clkout_o  (CLKOUT[i]),
         .ce_o      (CE[i])
      );
   end
endmodule
